rr_arb8: RTL and testbench

RR_ARB8 -- requirements
Module: rr_arb8

---
 rtl/arb_pkg.sv | 34 +++
 rtl/onehot_enc8.sv | 20 ++
 rtl/rr_arb8.sv | 121 ++++++++++++
 tb/tb_rr_arb8.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and round-robin search helper for the 8-way arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req, searching upward from last+1 with wrap.
    function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [IDX_W-1:0] last);
        rr_pick_t         res;
        logic [IDX_W-1:0] cand;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'(32'(last) + i);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_enc8.sv
// One-hot to binary encoder for the 8-bit grant vector; zero input gives zero.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin
        idx_c = '0;
        for (int unsigned b = 0; b < IDX_W; b++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (((i >> b) & 1) == 1) begin
                    idx_c[b] = idx_c[b] | onehot[i];
                end
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// 8-requester round-robin arbiter with registered one-hot grant.
// Optional hold-timeout preemption is enabled by defining ARB_TIMEOUT_EN.
module rr_arb8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb8: MAX_HOLD must be in 2..255");
    end

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] others;
    logic             holding;
    logic             timeout;
    rr_pick_t         pick;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_q, hold_d;
    logic       preempt_q, preempt_d;
`endif

    // Holder bit is masked out, so a release or a timeout search skips it.
    assign others  = req & ~gnt_q;
    assign holding = (state_q == GRANT) && ((req & gnt_q) != '0);
    assign pick    = rr_pick(others, last_q);

`ifdef ARB_TIMEOUT_EN
    assign timeout = holding && (hold_q >= HOLD_LAST) && (others != '0);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        preempt_d = 1'b0;
`endif
        if (holding && !timeout) begin
`ifdef ARB_TIMEOUT_EN
            // Saturate so a late competitor is served on the following edge.
            hold_d = (hold_q >= HOLD_LAST) ? HOLD_LAST : hold_q + 8'd1;
`endif
        end else if (pick.found) begin
            state_d = GRANT;
            gnt_d   = N_REQ'(1) << pick.idx;
            last_d  = pick.idx;
`ifdef ARB_TIMEOUT_EN
            hold_d    = 8'd0;
            preempt_d = timeout;
`endif
        end else begin
            state_d = IDLE;
            gnt_d   = '0;
`ifdef ARB_TIMEOUT_EN
            hold_d = 8'd0;
`endif
        end
    end

    onehot_enc8 u_enc (
        .onehot (gnt_d),
        .idx_c  (gnt_idx_d)
    );

    assign gnt_valid_d = (gnt_d != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            last_q      <= IDX_W'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            last_q      <= last_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8; timeout vectors run only when ARB_TIMEOUT_EN is defined.
module tb_rr_arb8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rr_arb8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_gnt(input string tag, input logic [7:0] g, input logic [2:0] i);
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
        check({tag, ".idx"}, 32'(gnt_idx), 32'(i));
        check({tag, ".valid"}, 32'(gnt_valid), 32'(g != 8'h00));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        expect_gnt("reset", 8'h00, 3'd0);
        check("reset.preempt", 32'(preempt), 32'd0);

        req = 8'h01; tick();
        expect_gnt("first", 8'h01, 3'd0);
        req = 8'h00; tick();
        expect_gnt("idle", 8'h00, 3'd0);

        // Full rotation with each holder dropping for one cycle in turn.
        do_reset();
        req = 8'hFF; tick();
        expect_gnt("rot0", 8'h01, 3'd0);
        tick();
        expect_gnt("rot_hold", 8'h01, 3'd0);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] cur, nxt;
            cur = 8'h01 << k;
            nxt = 8'h01 << ((k + 1) % 8);
            req = 8'hFF & ~cur; tick();
            expect_gnt($sformatf("rot%0d", k + 1), nxt, 3'((k + 1) % 8));
            check("rot.preempt", 32'(preempt), 32'd0);
        end

        // Holder 3, requester 5 waits, then takes over on release.
        do_reset();
        req = 8'h08; tick();
        expect_gnt("h3", 8'h08, 3'd3);
        req = 8'h28; tick();
        expect_gnt("h3_wait", 8'h08, 3'd3);
        req = 8'h20; tick();
        expect_gnt("h5", 8'h20, 3'd5);
        // Release and new arrival on the same edge.
        req = 8'h02; tick();
        expect_gnt("rel_new", 8'h02, 3'd1);

        // Reset mid-burst drops the grant, then arbitration resumes.
        do_reset();
        req = 8'h10; tick();
        expect_gnt("g4", 8'h10, 3'd4);
        rst = 1'b1; tick();
        expect_gnt("mid_rst", 8'h00, 3'd0);
        rst = 1'b0; tick();
        expect_gnt("after_rst", 8'h10, 3'd4);

        // Wrap from 7 back to 0.
        do_reset();
        req = 8'h80; tick();
        expect_gnt("g7", 8'h80, 3'd7);
        req = 8'h05; tick();
        expect_gnt("wrap0", 8'h01, 3'd0);
        req = 8'h04; tick();
        expect_gnt("wrap2", 8'h04, 3'd2);
        req = 8'h00; tick();
        expect_gnt("wrap_idle", 8'h00, 3'd0);

`ifdef ARB_TIMEOUT_EN
        // MAX_HOLD = 4: two requesters alternate every 4 cycles.
        do_reset();
        req = 8'h03;
        for (int c = 0; c < 16; c++) begin
            tick();
            check($sformatf("to.gnt%0d", c), 32'(gnt), ((c / 4) % 2 == 0) ? 32'h01 : 32'h02);
            check($sformatf("to.pre%0d", c), 32'(preempt), (c != 0 && c % 4 == 0) ? 32'd1 : 32'd0);
        end
        // Lone holder keeps the grant indefinitely.
        do_reset();
        req = 8'h04;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("lone.gnt%0d", c), 32'(gnt), 32'h04);
            check($sformatf("lone.pre%0d", c), 32'(preempt), 32'd0);
        end
`else
        // Without timeout a contested holder is never preempted.
        do_reset();
        req = 8'h03;
        for (int c = 0; c < 12; c++) begin
            tick();
            check($sformatf("nto.gnt%0d", c), 32'(gnt), 32'h01);
            check($sformatf("nto.pre%0d", c), 32'(preempt), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
